// File: rtl/ca_tx_gen_pkg.sv
// Shared C/A code constants: code geometry, G1/G2 taps and the PRN G2 start states.
// Also used by the receiver-side code generator.
package ca_tx_gen_pkg;

  localparam int CODE_LEN       = 1023;
  localparam int BITS_PER_EPOCH = 20;
  localparam int LFSR_W         = 10;

  // Registers shift right; bit 0 is the output stage, bit 9 takes the feedback.
  localparam logic [LFSR_W-1:0] G1_TAPS = 10'b0010000001;
  localparam logic [LFSR_W-1:0] G2_TAPS = 10'b0110010111;
  localparam logic [LFSR_W-1:0] G1_INIT = '1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // G2 initial states; bit 0 is the first chip shifted out.
  localparam int NUM_PRN = 4;
  function automatic logic [LFSR_W-1:0] prn_key_of(input int prn);
    logic [LFSR_W-1:0] k;
    case (prn)
      1:       k = 10'h3EC;
      2:       k = 10'h3D8;
      3:       k = 10'h3B0;
      4:       k = 10'h360;
      default: k = '0;
    endcase
    return k;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return {^(s & taps), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 Gold-code register pair with synchronous load (priority) and shift.
module ca_lfsr_pair
  import ca_tx_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [LFSR_W-1:0] g2_init,
  output logic [LFSR_W-1:0] g1,
  output logic [LFSR_W-1:0] g2,
  output logic              chip
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= G1_INIT;
      g2 <= '0;
    end else if (load) begin
      g1 <= G1_INIT;
      g2 <= g2_init;
    end else if (shift) begin
      g1 <= lfsr_step(g1, G1_TAPS);
      g2 <= lfsr_step(g2, G2_TAPS);
    end
  end

  assign chip = g1[0] ^ g2[0];

endmodule

// File: rtl/ca_tx_gen.sv
// C/A code transmitter: run/idle control, chip and period counters, and the
// navigation-bit hold/current path that modulates the chip stream.
module ca_tx_gen
  import ca_tx_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_enable,
  input  logic              prn_key_load,
  input  logic [LFSR_W-1:0] prn_key,
  input  logic              start,
  input  logic              stop,
  input  logic              nav_valid,
  input  logic              nav_bit,
  output logic              nav_ready,
  output logic              ca_chip,
  output logic              tx_chip,
  output logic              epoch,
  output logic              bit_epoch,
  output logic [9:0]        chip_count,
  output logic [4:0]        epoch_count,
  output logic              underrun,
  output logic              running
);

  state_t            state;
  logic [LFSR_W-1:0] key_reg;
  logic [LFSR_W-1:0] key_next;
  logic [LFSR_W-1:0] g1, g2;
  logic              hold_full, hold_bit, cur_bit;
  logic              start_go, advance, reload, wrap, boundary, nav_take;

  // A same-cycle key load is visible to a reload or start in that cycle.
  assign key_next = prn_key_load ? prn_key : key_reg;

  assign start_go = (state == ST_IDLE) && start && !stop;
  assign advance  = (state == ST_RUN) && chip_enable && !stop;
  assign reload   = advance && (chip_count == 10'(CODE_LEN - 1));
  assign wrap     = reload && (epoch_count == 5'(BITS_PER_EPOCH - 1));
  assign boundary = start_go || wrap;

  assign nav_ready = !hold_full;
  assign nav_take  = nav_valid && nav_ready;

  ca_lfsr_pair u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_go || reload),
    .shift   (advance && !reload),
    .g2_init (key_next),
    .g1      (g1),
    .g2      (g2),
    .chip    (ca_chip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      running     <= 1'b0;
      chip_count  <= '0;
      epoch_count <= '0;
      epoch       <= 1'b0;
      bit_epoch   <= 1'b0;
    end else begin
      epoch     <= 1'b0;
      bit_epoch <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        running <= 1'b0;
      end else if (start_go) begin
        state       <= ST_RUN;
        running     <= 1'b1;
        chip_count  <= '0;
        epoch_count <= '0;
        epoch       <= 1'b1;
        bit_epoch   <= 1'b1;
      end else if (advance) begin
        if (reload) begin
          chip_count <= '0;
          epoch      <= 1'b1;
          if (wrap) begin
            epoch_count <= '0;
            bit_epoch   <= 1'b1;
          end else begin
            epoch_count <= epoch_count + 5'd1;
          end
        end else begin
          chip_count <= chip_count + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_reg <= '0;
    else if (prn_key_load) key_reg <= prn_key;
  end

  // At a boundary with an empty hold, an offered bit goes straight to current
  // and the hold is left empty, so nav_ready never drops for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_bit  <= 1'b0;
      cur_bit   <= 1'b0;
    end else if (boundary) begin
      if (hold_full) begin
        cur_bit   <= hold_bit;
        hold_full <= 1'b0;
      end else if (nav_valid) begin
        cur_bit <= nav_bit;
      end else begin
        cur_bit <= 1'b0;
      end
    end else begin
      if (stop) cur_bit <= 1'b0;
      if (nav_take) begin
        hold_bit  <= nav_bit;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun <= 1'b0;
    else if (boundary && !hold_full && !nav_valid) underrun <= 1'b1;
    else if (prn_key_load) underrun <= 1'b0;
  end

  assign tx_chip = running && (ca_chip ^ cur_bit);

endmodule

// File: tb/tb_ca_tx_gen.sv
// Directed bench for ca_tx_gen: PRN table vectors plus hand-written
// sequences for nav underrun/bypass, mid-period key change and reset abort.
module tb_ca_tx_gen;

  logic       clk = 1'b0;
  logic       rst, chip_enable, prn_key_load, start, stop, nav_valid, nav_bit;
  logic [9:0] prn_key;
  logic       nav_ready, ca_chip, tx_chip, epoch, bit_epoch, underrun, running;
  logic [9:0] chip_count;
  logic [4:0] epoch_count;

  ca_tx_gen dut (
    .clk(clk), .rst(rst), .chip_enable(chip_enable), .prn_key_load(prn_key_load),
    .prn_key(prn_key), .start(start), .stop(stop), .nav_valid(nav_valid),
    .nav_bit(nav_bit), .nav_ready(nav_ready), .ca_chip(ca_chip), .tx_chip(tx_chip),
    .epoch(epoch), .bit_epoch(bit_epoch), .chip_count(chip_count),
    .epoch_count(epoch_count), .underrun(underrun), .running(running)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0] key;
    logic [9:0] first10;
  } vec_t;
  vec_t vecs[4];

  localparam logic [9:0] K1 = 10'h3EC;
  localparam logic [9:0] K2 = 10'h3D8;
  localparam logic [9:0] K3 = 10'h3B0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    chip_enable = 1'b1;
    tick();
    chip_enable = 1'b0;
  endtask

  task automatic load_key(input logic [9:0] k);
    prn_key = k;
    prn_key_load = 1'b1;
    tick();
    prn_key_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Reference chips from the recurrences s[n+10] = XOR of tapped earlier outputs.
  function automatic logic [1022:0] gen_code(input logic [9:0] key);
    logic s1[0:1032];
    logic s2[0:1032];
    logic [1022:0] c;
    for (int k = 0; k < 10; k++) begin
      s1[k] = 1'b1;
      s2[k] = key[k];
    end
    for (int n = 0; n < 1023; n++) begin
      s1[n+10] = s1[n+7] ^ s1[n];
      s2[n+10] = s2[n+8] ^ s2[n+7] ^ s2[n+4] ^ s2[n+2] ^ s2[n+1] ^ s2[n];
      c[n] = s1[n] ^ s2[n];
    end
    return c;
  endfunction

  // Compare chips lo..hi against the reference, one strobe per chip.
  task automatic collect(input logic [1022:0] r, input int lo, input int hi,
                         input string name, output int f10, output int ep);
    int mism;
    mism = 0; f10 = 0; ep = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i - lo < 10) f10 = (f10 << 1) | int'(ca_chip);
      if (ca_chip !== r[i]) mism++;
      strobe();
      if (epoch) ep++;
    end
    check(name, mism, 0);
  endtask

  initial begin
    logic [1022:0] r1, r2, r3, rv;
    int f10, ep, be, mism;

    rst = 1'b1; chip_enable = 0; prn_key_load = 0; prn_key = '0;
    start = 0; stop = 0; nav_valid = 0; nav_bit = 0;
    vecs[0] = '{10'h3EC, 10'o1440};
    vecs[1] = '{10'h3D8, 10'o1620};
    vecs[2] = '{10'h3B0, 10'o1710};
    vecs[3] = '{10'h360, 10'o1744};
    r1 = gen_code(K1); r2 = gen_code(K2); r3 = gen_code(K3);

    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_running", running, 0);
    check("rst_chip_count", chip_count, 0);
    check("rst_epoch_count", epoch_count, 0);
    check("rst_epoch", epoch, 0);
    check("rst_bit_epoch", bit_epoch, 0);
    check("rst_underrun", underrun, 0);
    check("rst_tx_chip", tx_chip, 0);
    check("rst_nav_ready", nav_ready, 1);

    for (int i = 0; i < 5; i++) strobe();
    check("idle_ce_chip_count", chip_count, 0);
    check("idle_ce_ca_chip", ca_chip, 1);

    for (int v = 0; v < 4; v++) begin
      rv = gen_code(vecs[v].key);
      load_key(vecs[v].key);
      check("tbl_underrun_clr", underrun, 0);
      do_start();
      check("tbl_run", running, 1);
      check("tbl_epoch0", epoch, 1);
      check("tbl_bit_epoch0", bit_epoch, 1);
      check("tbl_underrun_set", underrun, 1);
      collect(rv, 0, 1022, "tbl_period", f10, ep);
      check("tbl_first10", f10, vecs[v].first10);
      check("tbl_epochs", ep, 1);
      check("tbl_epoch_count", epoch_count, 1);
      collect(rv, 0, 1022, "tbl_period2", f10, ep);
      check("tbl_epoch_count2", epoch_count, 2);
      for (int i = 0; i < 3; i++) strobe();
      do_start();
      check("tbl_start_ignored", chip_count, 3);
      do_stop();
      check("tbl_stop_running", running, 0);
      check("tbl_stop_tx", tx_chip, 0);
    end

    // Preloaded nav bit 1 spans one whole data bit, then the second boundary underruns.
    load_key(K1);
    nav_valid = 1; nav_bit = 1;
    tick();
    nav_valid = 0; nav_bit = 0;
    check("nav_hold_full", nav_ready, 0);
    do_start();
    check("nav_ready_after_start", nav_ready, 1);
    check("nav_bit_epoch0", bit_epoch, 1);
    check("nav_no_underrun", underrun, 0);
    mism = 0; be = 0; ep = 0;
    for (int i = 0; i < 20460; i++) begin
      if (tx_chip !== ~r1[i % 1023]) mism++;
      strobe();
      if (bit_epoch) be++;
      if (epoch) ep++;
    end
    check("nav_tx_inverted", mism, 0);
    check("nav_bit_epochs", be, 1);
    check("nav_epochs", ep, 20);
    check("nav_bit_epoch_20460", bit_epoch, 1);
    check("nav_epoch_count_wrap", epoch_count, 0);
    check("nav_underrun", underrun, 1);
    check("nav_tx_plain", tx_chip, r1[0]);
    mism = 0;
    for (int i = 0; i < 5; i++) begin
      strobe();
      if (tx_chip !== r1[i+1]) mism++;
    end
    check("nav_tx_plain_run", mism, 0);
    load_key(K1);
    check("nav_underrun_clr", underrun, 0);

    // Bypass: empty hold, nav_valid on the boundary cycle itself.
    do_stop();
    check("byp_hold_empty", nav_ready, 1);
    load_key(K1);
    nav_valid = 1; nav_bit = 1; start = 1;
    tick();
    nav_valid = 0; nav_bit = 0; start = 0;
    check("byp_underrun", underrun, 0);
    check("byp_nav_ready", nav_ready, 1);
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_chip !== ~r1[i]) mism++;
      strobe();
    end
    check("byp_tx_inverted", mism, 0);

    // Key change mid-period takes effect at the next reload; same-cycle load+reload uses new key.
    do_stop();
    load_key(K1);
    do_start();
    for (int i = 0; i < 500; i++) strobe();
    load_key(K2);
    check("key_chip_count", chip_count, 500);
    collect(r1, 500, 1022, "key_prn1_tail", f10, ep);
    check("key_tail_epoch", ep, 1);
    collect(r2, 0, 1021, "key_prn2", f10, ep);
    check("key_prn2_first10", f10, 10'o1620);
    prn_key = K3; prn_key_load = 1'b1;
    strobe();
    prn_key_load = 1'b0;
    check("key_same_cycle_epoch", epoch, 1);
    collect(r3, 0, 9, "key_prn3", f10, ep);
    check("key_prn3_first10", f10, 10'o1710);

    // Asynchronous reset mid-period.
    do_stop();
    load_key(K1);
    do_start();
    for (int i = 0; i < 700; i++) strobe();
    check("arst_chip700", chip_count, 700);
    #2 rst = 1'b1;
    #1;
    check("arst_running", running, 0);
    check("arst_chip_count", chip_count, 0);
    check("arst_epoch_count", epoch_count, 0);
    check("arst_tx", tx_chip, 0);
    check("arst_epoch", epoch, 0);
    check("arst_underrun", underrun, 0);
    check("arst_nav_ready", nav_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_pulse", {epoch, bit_epoch, running}, 0);
    load_key(K1);
    do_start();
    check("arst_restart_chip", chip_count, 0);
    check("arst_restart_epoch", epoch, 1);
    collect(r1, 0, 9, "arst_restart_seq", f10, ep);
    check("arst_first10", f10, 10'o1440);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
